leds_uart_reporter: RTL and testbench

LEDS_UART_REPORTER -- requirements
Module: leds_uart_reporter

---
 rtl/leds_report_pkg.sv | 29 ++
 rtl/uart_tx_byte.sv | 112 +++++++++++
 rtl/leds_uart_reporter.sv | 116 +++++++++++
 tb/tb_leds_uart_reporter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/leds_report_pkg.sv
// Shared constants, transmitter state encoding and the character lookup used
// by the LED-word UART reporter.
package leds_report_pkg;

    localparam logic [7:0] ASCII_0          = 8'h30;
    localparam logic [7:0] ASCII_1          = 8'h31;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam int         CHARS_PER_REPORT = 33;
    localparam int         CHAR_IDX_W       = 6;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Character idx of a report: bits 31..0 as '0'/'1', then a line feed.
    function automatic logic [7:0] report_char(input logic [31:0]           word,
                                               input logic [CHAR_IDX_W-1:0] idx);
        logic [4:0] bit_sel;
        bit_sel = 5'd31 - idx[4:0];
        if (idx >= CHAR_IDX_W'(CHARS_PER_REPORT - 1)) begin
            return ASCII_LF;
        end
        return word[bit_sel] ? ASCII_1 : ASCII_0;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with a valid/ready input. Ready is also raised in the
// last stop-bit cycle so a following byte starts with no idle gap.
module uart_tx_byte
    import leds_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       idle
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shifter, shifter_next;
    logic              txd_next;
    logic              bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign ready   = (state == IDLE) || ((state == STOP) && bit_end);
    assign idle    = (state == IDLE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shifter_next  = shifter;
        txd_next      = txd;

        unique case (state)
            IDLE: begin
                if (valid) begin
                    state_next    = START;
                    baud_cnt_next = '0;
                    shifter_next  = data;
                    txd_next      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next    = DATA;
                    baud_cnt_next = '0;
                    bit_idx_next  = 3'd0;
                    txd_next      = shifter[0];
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shifter_next = {1'b0, shifter[7:1]};
                        txd_next     = shifter[1];
                    end
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (valid) begin
                        state_next   = START;
                        shifter_next = data;
                        txd_next     = 1'b0;
                    end else begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shifter  <= shifter_next;
            txd      <= txd_next;
        end
    end

endmodule

// File: rtl/leds_uart_reporter.sv
// Watches a 32-bit LED word, queues every change in a small FIFO and reports
// each snapshot over UART as 32 ASCII binary digits plus a line feed.
module leds_uart_reporter
    import leds_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] LEDS,
    output logic        TXD,
    output logic        BUSY,
    output logic        OVERFLOW
);

    localparam int                    PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [CHAR_IDX_W-1:0] LAST_CHAR = CHAR_IDX_W'(CHARS_PER_REPORT - 1);

    logic [31:0]           prev_leds;
    logic [31:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [31:0]           fifo_head;

    logic [31:0]           snapshot;
    logic [CHAR_IDX_W-1:0] char_idx;
    logic                  report_active;

    logic                  change;
    logic                  push;
    logic                  pop;
    logic                  take;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_idle;
    logic [7:0]            tx_data;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[PTR_W-1:0]];

    // The first character of a new report comes straight from the FIFO head,
    // so the pop and the start bit land on the same edge.
    assign tx_valid = report_active || !fifo_empty;
    assign tx_data  = report_active ? report_char(snapshot, char_idx)
                                    : report_char(fifo_head, '0);
    assign take     = tx_valid && tx_ready;
    assign pop      = take && !report_active;

    assign change   = (LEDS != prev_leds);
    assign push     = change && (!fifo_full || pop);

    assign BUSY     = !tx_idle || !fifo_empty;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prev_leds     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            OVERFLOW      <= 1'b0;
            snapshot      <= '0;
            char_idx      <= '0;
            report_active <= 1'b0;
        end else begin
            prev_leds <= LEDS;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (change && !push) begin
                OVERFLOW <= 1'b1;
            end

            if (take) begin
                if (!report_active) begin
                    snapshot      <= fifo_head;
                    char_idx      <= CHAR_IDX_W'(1);
                    report_active <= 1'b1;
                end else if (char_idx == LAST_CHAR) begin
                    char_idx      <= '0;
                    report_active <= 1'b0;
                end else begin
                    char_idx <= char_idx + CHAR_IDX_W'(1);
                end
            end
        end
    end

    // NOTE: FIFO storage has no reset; the reset pointers alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= LEDS;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (CLK),
        .rst_n(RESET),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .txd  (TXD),
        .idle (tx_idle)
    );

endmodule

// File: tb/tb_leds_uart_reporter.sv
// Directed bench for leds_uart_reporter: a UART receiver decodes TXD into a
// byte queue that is compared against reports built from the LED values.
module tb_leds_uart_reporter;

    localparam int CPB           = 4;
    localparam int DEPTH         = 4;
    localparam int BYTE_CYCLES   = 10 * CPB;
    localparam int REPORT_CYCLES = 330 * CPB;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] leds    = '0;
    logic        txd;
    logic        busy;
    logic        overflow;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          cyc       = 0;
    int          frame_err = 0;
    bit          rx_abort  = 1'b0;
    logic [7:0]  rx_q [$];
    int          rx_t [$];

    leds_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLK     (clk),
        .RESET   (reset_n),
        .LEDS    (leds),
        .TXD     (txd),
        .BUSY    (busy),
        .OVERFLOW(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge reset_n) rx_abort = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Samples each bit 1.5 cycles after it starts; frames cut by reset are discarded.
    initial begin : rx_monitor
        logic [7:0] b;
        logic       ok;
        int         t0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && txd === 1'b0) begin
                t0       = cyc;
                rx_abort = 1'b0;
                @(negedge clk);
                ok = (txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    tick(CPB);
                    b[i] = txd;
                end
                tick(CPB);
                ok = ok && (txd === 1'b1);
                if (!rx_abort) begin
                    if (!ok) frame_err++;
                    rx_q.push_back(b);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < budget) begin
            tick(1);
            t++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_gaps(input string tag, input int n);
        int bad;
        bad = (rx_t.size() < n) ? 1 : 0;
        for (int i = 1; i < n && i < rx_t.size(); i++) begin
            if (rx_t[i] - rx_t[i-1] != BYTE_CYCLES) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic check_report(input string tag, input logic [31:0] word);
        string      s;
        logic [7:0] got;
        logic [7:0] exp;
        s = $sformatf("%032b", word);
        for (int i = 0; i < 33; i++) begin
            exp = (i == 32) ? 8'h0A : s[i];
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
            if (rx_t.size() > 0) void'(rx_t.pop_front());
            check($sformatf("%s byte %0d", tag, i), 32'(got), 32'(exp));
        end
    endtask

    initial begin : main
        int          bad;
        logic [31:0] ovf_vals [6];

        ovf_vals[0] = 32'h1111_1111;
        ovf_vals[1] = 32'h2222_2222;
        ovf_vals[2] = 32'h8000_0001;
        ovf_vals[3] = 32'hFFFF_FFFF;
        ovf_vals[4] = 32'h0000_FFFF;
        ovf_vals[5] = 32'h1234_5678;

        // Reset and a long quiet interval with LEDS held at zero.
        tick(5);
        check("reset txd", 32'(txd), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (txd !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) bad++;
        end
        check("quiet cycles bad", 32'(bad), 32'd0);
        check("quiet bytes", 32'(rx_q.size()), 32'd0);

        // Single change to 5: start bit one cycle after the capture edge.
        leds = 32'h0000_0005;
        tick(1);
        check("single txd at capture", 32'(txd), 32'd1);
        check("single busy at capture", 32'(busy), 32'd1);
        tick(1);
        check("single start bit", 32'(txd), 32'd0);
        tick(REPORT_CYCLES - 1);
        check("single busy last cycle", 32'(busy), 32'd1);
        tick(1);
        check("single busy released", 32'(busy), 32'd0);
        wait_bytes("single byte count", 33, 100);
        check_gaps("single gaps", 33);
        check_report("single", 32'h0000_0005);

        // Three changes on consecutive edges, sent back-to-back.
        leds = 32'h1; tick(1);
        leds = 32'h2; tick(1);
        leds = 32'h3; tick(1);
        wait_bytes("b2b byte count", 99, 3 * REPORT_CYCLES + 200);
        check_gaps("b2b gaps", 99);
        check_report("b2b r1", 32'h1);
        check_report("b2b r2", 32'h2);
        check_report("b2b r3", 32'h3);
        check("b2b overflow", 32'(overflow), 32'd0);
        wait_idle("b2b idle", 200);

        // Six changes in a row: one in flight plus four queued, sixth dropped.
        for (int i = 0; i < 6; i++) begin
            leds = ovf_vals[i];
            tick(1);
            if (i == 4) check("ovf clear at full", 32'(overflow), 32'd0);
        end
        check("ovf set on drop", 32'(overflow), 32'd1);
        // Change lands exactly on the edge where the full FIFO pops: must be kept.
        tick(REPORT_CYCLES - 5);
        leds = 32'hCAFE_0001;
        wait_bytes("ovf byte count", 198, 6 * REPORT_CYCLES + 200);
        check_gaps("ovf gaps", 198);
        for (int i = 0; i < 5; i++) begin
            check_report($sformatf("ovf r%0d", i + 1), ovf_vals[i]);
        end
        check_report("ovf push on pop", 32'hCAFE_0001);
        check("ovf sticky", 32'(overflow), 32'd1);
        wait_idle("ovf idle", 200);

        // Reset during a data bit of byte 3, then a full resend.
        leds = 32'hA5A5_A5A5;
        tick(131);
        check("mid bytes before reset", 32'(rx_q.size()), 32'd3);
        check("mid data bit low", 32'(txd), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid reset txd", 32'(txd), 32'd1);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        tick(49);
        rx_q.delete();
        rx_t.delete();
        reset_n = 1'b1;
        tick(1);
        check("resend txd at capture", 32'(txd), 32'd1);
        tick(1);
        check("resend start bit", 32'(txd), 32'd0);
        wait_bytes("resend byte count", 33, REPORT_CYCLES + 100);
        check_gaps("resend gaps", 33);
        check_report("resend", 32'hA5A5_A5A5);
        wait_idle("resend idle", 200);

        check("framing errors", 32'(frame_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
